// File: rtl/reg_file_param.sv
// Parameterised register file: one write port, two registered read ports,
// write-first bypass, optional hardwired-zero entry 0, and a one-entry-per-cycle
// clear sweep controlled by a two-state FSM.
module reg_file_param #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned ZERO_R0   = 0,
    parameter int unsigned INIT_MODE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic              wready,
    input  logic [ADDR_W-1:0] raddr_1,
    output logic [DATA_W-1:0] rdata_1,
    input  logic [ADDR_W-1:0] raddr_2,
    output logic [DATA_W-1:0] rdata_2,
    input  logic              clr_req,
    output logic              busy
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] rdata_1_q, rdata_1_d;
    logic [DATA_W-1:0] rdata_2_q, rdata_2_d;
    logic              wr_en;

    // Status decoded straight from the state flop; writes are blocked while sweeping.
    assign busy    = (state_q == SWEEP);
    assign wready  = ~busy;
    assign rdata_1 = rdata_1_q;
    assign rdata_2 = rdata_2_q;

    // Next state: sweep control, memory update, and reads taken from the post-edge contents.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mem_d   = mem_q;
        wr_en   = we && (state_q == IDLE) && !((ZERO_R0 != 0) && (waddr == '0));

        if (wr_en) begin
            mem_d[waddr] = wdata;
        end

        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                end
            end
            SWEEP: begin
                mem_d[idx_q] = '0;
                idx_d        = idx_q + ADDR_W'(1);
                if (idx_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Reading the next contents gives write-first and clear-first bypass for free.
        rdata_1_d = mem_d[raddr_1];
        rdata_2_d = mem_d[raddr_2];
    end

    // State, index, storage and read registers; reset reloads the init pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            rdata_1_q <= '0;
            rdata_2_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                if ((INIT_MODE != 0) && !((ZERO_R0 != 0) && (i == 0))) begin
                    mem_q[i] <= DATA_W'(i);
                end else begin
                    mem_q[i] <= '0;
                end
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rdata_1_q <= rdata_1_d;
            rdata_2_q <= rdata_2_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Randomised bench for reg_file_param: a default instance and a ZERO_R0 instance
// share stimulus and are compared against an array model; a DATA_W=4/ADDR_W=6
// instance gets directed wrap and sweep-length checks.
module tb_reg_file_param;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          we, clr_req;
    logic [AW-1:0] waddr, raddr_1, raddr_2;
    logic [DW-1:0] wdata;
    logic          wready, busy, wready_z, busy_z;
    logic [DW-1:0] rd1, rd2, rd1_z, rd2_z;

    logic       w_we, w_clr, w_wready, w_busy;
    logic [5:0] w_waddr, w_ra1, w_ra2;
    logic [3:0] w_wdata, w_rd1, w_rd2;

    always #5 clk = ~clk;

    reg_file_param dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wready(wready),
        .raddr_1(raddr_1), .rdata_1(rd1), .raddr_2(raddr_2), .rdata_2(rd2),
        .clr_req(clr_req), .busy(busy)
    );

    reg_file_param #(.ZERO_R0(1)) dut_z (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wready(wready_z),
        .raddr_1(raddr_1), .rdata_1(rd1_z), .raddr_2(raddr_2), .rdata_2(rd2_z),
        .clr_req(clr_req), .busy(busy_z)
    );

    reg_file_param #(.DATA_W(4), .ADDR_W(6), .INIT_MODE(1)) dut_w (
        .clk(clk), .rst(rst), .we(w_we), .waddr(w_waddr), .wdata(w_wdata), .wready(w_wready),
        .raddr_1(w_ra1), .rdata_1(w_rd1), .raddr_2(w_ra2), .rdata_2(w_rd2),
        .clr_req(w_clr), .busy(w_busy)
    );

    // Reference model: [0] = default instance, [1] = ZERO_R0 instance.
    int unsigned m_mem [2][DEPTH];
    int unsigned m_left;
    int unsigned m_ptr;
    int unsigned exp1 [2];
    int unsigned exp2 [2];
    int          checks   = 0;
    int          failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[0][i] = i % 256;
            m_mem[1][i] = (i == 0) ? 0 : i % 256;
        end
        m_left = 0;
        m_ptr  = 0;
        for (int k = 0; k < 2; k++) begin
            exp1[k] = 0;
            exp2[k] = 0;
        end
    endtask

    // One clock: apply inputs, check wready, advance model and DUTs, check outputs.
    task automatic drive_cycle(input logic we_i, input int unsigned wa, input int unsigned wd,
                               input int unsigned r1, input int unsigned r2, input logic clr_i);
        logic accepted;
        we      = we_i;
        waddr   = AW'(wa);
        wdata   = DW'(wd);
        raddr_1 = AW'(r1);
        raddr_2 = AW'(r2);
        clr_req = clr_i;
        #1;
        check("wready", 32'(wready), 32'(m_left == 0));
        check("wready_z", 32'(wready_z), 32'(m_left == 0));
        @(posedge clk);
        accepted = we_i && (m_left == 0);
        for (int k = 0; k < 2; k++) begin
            if (accepted && !(k == 1 && wa == 0)) m_mem[k][wa] = wd;
            if (m_left > 0) m_mem[k][m_ptr] = 0;
        end
        if (m_left > 0) begin
            m_ptr  = (m_ptr + 1) % DEPTH;
            m_left = m_left - 1;
        end else if (clr_i) begin
            m_left = DEPTH;
            m_ptr  = 0;
        end
        for (int k = 0; k < 2; k++) begin
            exp1[k] = m_mem[k][r1];
            exp2[k] = m_mem[k][r2];
        end
        @(negedge clk);
        check("rdata_1", 32'(rd1), exp1[0]);
        check("rdata_2", 32'(rd2), exp2[0]);
        check("busy", 32'(busy), 32'(m_left != 0));
        check("rdata_1_z", 32'(rd1_z), exp1[1]);
        check("rdata_2_z", 32'(rd2_z), exp2[1]);
        check("busy_z", 32'(busy_z), 32'(m_left != 0));
        we      = 1'b0;
        clr_req = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        rst = 1'b1;
        we = 1'b0; clr_req = 1'b0; waddr = '0; wdata = '0; raddr_1 = '0; raddr_2 = '0;
        w_we = 1'b0; w_clr = 1'b0; w_waddr = '0; w_wdata = '0; w_ra1 = '0; w_ra2 = '0;
        model_reset();
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wready", 32'(wready), 32'd1);
        check("rst_rdata_1", 32'(rd1), 32'd0);
        check("rst_rdata_2", 32'(rd2), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset contents, write-first bypass, and the hardwired-zero entry.
        drive_cycle(1'b0, 0, 0, 5, 31, 1'b0);
        check("init_5", 32'(rd1), 32'h05);
        check("init_31", 32'(rd2), 32'h1F);
        drive_cycle(1'b1, 3, 8'hA5, 3, 4, 1'b0);
        check("bypass_3", 32'(rd1), 32'hA5);
        drive_cycle(1'b1, 0, 8'h77, 0, 0, 1'b0);
        drive_cycle(1'b0, 0, 0, 0, 3, 1'b0);
        check("zr_read0", 32'(rd1_z), 32'h00);
        check("zr_read3", 32'(rd2_z), 32'hA5);
        check("nozr_read0", 32'(rd1), 32'h77);

        // Random traffic with occasional clear requests.
        for (int n = 0; n < 300; n++) begin
            drive_cycle(1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1),
                        $urandom_range(0, 255), $urandom_range(0, DEPTH - 1),
                        $urandom_range(0, DEPTH - 1), ($urandom_range(0, 39) == 0));
        end

        // Full clear: write in the request cycle, a dropped write mid-sweep, busy length.
        for (int n = 0; n < 40 && m_left != 0; n++) drive_cycle(1'b0, 0, 0, 0, 0, 1'b0);
        for (int i = 1; i < DEPTH; i++) drive_cycle(1'b1, i, 8'hC0 | i, i, i, 1'b0);
        drive_cycle(1'b1, 9, 8'h33, 9, 10, 1'b1);
        check("clr_cycle_write", 32'(rd1), 32'h33);
        busy_cnt = 0;
        for (int n = 0; n < 100 && busy; n++) begin
            busy_cnt++;
            drive_cycle(n == 5, 7, 8'h5A, $urandom_range(0, DEPTH - 1), 7, n == 8);
        end
        check("sweep_len", 32'(busy_cnt), 32'd32);
        for (int i = 0; i < DEPTH; i += 2) begin
            drive_cycle(1'b0, 0, 0, i, i + 1, 1'b0);
            check("cleared_a", 32'(rd1), 32'd0);
            check("cleared_b", 32'(rd2), 32'd0);
        end

        // Reset part-way through a sweep restores the init pattern.
        drive_cycle(1'b0, 0, 0, 0, 0, 1'b1);
        for (int n = 0; n < 10; n++) drive_cycle(1'b0, 0, 0, n, n, 1'b0);
        rst = 1'b1;
        #1;
        model_reset();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_wready", 32'(wready), 32'd1);
        check("abort_rdata_1", 32'(rd1), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive_cycle(1'b1, 4, 8'hC3, 20, 2, 1'b0);
        check("abort_e20", 32'(rd1), 32'h14);
        check("abort_e2", 32'(rd2), 32'h02);
        drive_cycle(1'b0, 0, 0, 4, 5, 1'b0);
        check("first_write", 32'(rd1), 32'hC3);

        // Narrow/deep instance: init wraps mod 16 and the sweep lasts 64 cycles.
        w_ra1 = 6'd17;
        w_ra2 = 6'd63;
        @(posedge clk);
        @(negedge clk);
        check("w_init_17", 32'(w_rd1), 32'h1);
        check("w_init_63", 32'(w_rd2), 32'hF);
        w_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        w_clr = 1'b0;
        busy_cnt = 0;
        for (int n = 0; n < 200 && w_busy; n++) begin
            busy_cnt++;
            check("w_wready", 32'(w_wready), 32'd0);
            @(negedge clk);
        end
        check("w_sweep_len", 32'(busy_cnt), 32'd64);
        check("w_cleared_17", 32'(w_rd1), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
